// File: rtl/seven_seg_scan_controller_if.sv
// Shadow-buffer write port and commit handshake for seven_seg_scan_controller.
//
// Signals:
//   wr_valid     writer -> ctrl  shadow write request
//   wr_ready     ctrl -> writer  write accepted when wr_valid && wr_ready
//   wr_index     writer -> ctrl  target digit (IDX_W bits)
//   wr_value     writer -> ctrl  hex value 0..F
//   wr_dp        writer -> ctrl  decimal point (segment h)
//   wr_enable    writer -> ctrl  1 = digit lit
//   commit       writer -> ctrl  request shadow->active copy at next frame boundary
//   commit_done  ctrl -> writer  one-cycle pulse when the copy has happened
//
// Modports: master = user logic filling the shadow buffer, slave = controller.
interface seven_seg_scan_controller_if #(
  parameter int N_DIGITS = 8
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_index;
  logic [3:0]       wr_value;
  logic             wr_dp;
  logic             wr_enable;
  logic             commit;
  logic             commit_done;

  modport master (
    output wr_valid, wr_index, wr_value, wr_dp, wr_enable, commit,
    input  wr_ready, commit_done
  );

  modport slave (
    input  wr_valid, wr_index, wr_value, wr_dp, wr_enable, commit,
    output wr_ready, commit_done
  );
endinterface

// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed scan controller for an N-digit seven-segment display.
// Keeps a shadow and an active buffer of per-digit {enable, dp, value}.
// Writers fill the shadow; a commit copies shadow to active only on the
// last cycle of a frame so a displayed frame never mixes old and new data.
// Each digit gets BLANK_CYCLES dark cycles followed by SCAN_DIV lit cycles.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high
//   wr_bus       slave side of the shadow write / commit interface
//   abcdefgh     segments, bit7=a .. bit1=g, bit0=h (dp); 1 = on
//   digit        one-hot digit select; 1 = active
//   frame_start  one-cycle pulse when the scan wraps back to digit 0
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | all segments and digits off for BLANK_CYCLES (anti-ghosting)
// ST_SHOW  | digit scan_idx lit from the active buffer for SCAN_DIV cycles
module seven_seg_scan_controller #(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  seven_seg_scan_controller_if.slave wr_bus,
  output logic [7:0]                abcdefgh,
  output logic [N_DIGITS-1:0]       digit,
  output logic                      frame_start
);

  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int MAX_LEN = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int TMR_W   = $clog2(MAX_LEN + 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  typedef struct packed {
    logic       enable;
    logic       dp;
    logic [3:0] value;
  } entry_t;

  state_t           state_q;
  logic [IDX_W-1:0] scan_idx_q;
  logic [TMR_W-1:0] timer_q;
  logic             pending_q;
  logic             wr_ready_q;
  logic             commit_done_q;
  entry_t           shadow_q [N_DIGITS];
  entry_t           active_q [N_DIGITS];

  logic                last_blank;
  logic                last_show;
  logic                last_digit;
  logic                boundary;
  logic                commit_fire;
  logic                pending_d;
  logic                wr_fire;
  logic                idx_ok;
  entry_t              cur_entry;
  logic [7:0]          seg_raw;
  logic [7:0]          lit_seg;
  logic [N_DIGITS-1:0] lit_digit;

  function automatic logic [7:0] hex7seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    last_blank  = (timer_q == TMR_W'(BLANK_CYCLES - 1));
    last_show   = (timer_q == TMR_W'(SCAN_DIV - 1));
    last_digit  = (scan_idx_q == IDX_W'(N_DIGITS - 1));
    boundary    = (state_q == ST_SHOW) && last_show && last_digit;
    commit_fire = boundary && pending_q;

    // A commit arriving on the boundary cycle itself only arms pending;
    // the copy then waits for the following boundary.
    pending_d = pending_q;
    if (commit_fire) begin
      pending_d = 1'b0;
    end else if (wr_bus.commit && !pending_q) begin
      pending_d = 1'b1;
    end

    wr_fire = wr_bus.wr_valid && wr_ready_q;
    // Out-of-range indices are still handshaken so a writer never stalls.
    idx_ok  = ({1'b0, wr_bus.wr_index} < (IDX_W + 1)'(N_DIGITS));

    cur_entry = active_q[scan_idx_q];
    seg_raw   = hex7seg(cur_entry.value);
    lit_seg   = cur_entry.enable ? {seg_raw[7:1], cur_entry.dp} : 8'h00;
    lit_digit = cur_entry.enable ? (N_DIGITS'(1) << scan_idx_q) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      scan_idx_q    <= '0;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      wr_ready_q    <= 1'b0;
      commit_done_q <= 1'b0;
      frame_start   <= 1'b0;
      abcdefgh      <= '0;
      digit         <= '0;
      for (int i = 0; i < N_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      pending_q     <= pending_d;
      wr_ready_q    <= !pending_d;
      commit_done_q <= commit_fire;
      frame_start   <= 1'b0;

      // Writes are blocked while pending, so a write never races the copy.
      if (wr_fire && idx_ok) begin
        shadow_q[wr_bus.wr_index] <= '{enable: wr_bus.wr_enable,
                                       dp:     wr_bus.wr_dp,
                                       value:  wr_bus.wr_value};
      end

      if (commit_fire) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end

      case (state_q)
        ST_BLANK: begin
          if (last_blank) begin
            state_q  <= ST_SHOW;
            timer_q  <= '0;
            digit    <= lit_digit;
            abcdefgh <= lit_seg;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        ST_SHOW: begin
          if (last_show) begin
            state_q  <= ST_BLANK;
            timer_q  <= '0;
            digit    <= '0;
            abcdefgh <= '0;
            if (last_digit) begin
              scan_idx_q  <= '0;
              frame_start <= 1'b1;
            end else begin
              scan_idx_q <= scan_idx_q + IDX_W'(1);
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: begin
          state_q <= ST_BLANK;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign wr_bus.wr_ready    = wr_ready_q;
  assign wr_bus.commit_done = commit_done_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Bench for seven_seg_scan_controller: a 4-digit and a 6-digit instance
// (SCAN_DIV=4, BLANK_CYCLES=2) share clock and reset. The reference model
// tracks cycles since reset and derives the display from frame position.
module tb_seven_seg_scan_controller;
  localparam int B    = 2;
  localparam int S    = 4;
  localparam int SLOT = B + S;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_seg_scan_controller_if #(.N_DIGITS(4)) if4 ();
  seven_seg_scan_controller_if #(.N_DIGITS(6)) if6 ();

  logic [7:0] seg4, seg6;
  logic [3:0] dig4;
  logic [5:0] dig6;
  logic       fs4, fs6;

  seven_seg_scan_controller #(.N_DIGITS(4), .SCAN_DIV(S), .BLANK_CYCLES(B)) dut4 (
    .clock(clk), .reset(rst), .wr_bus(if4),
    .abcdefgh(seg4), .digit(dig4), .frame_start(fs4));

  seven_seg_scan_controller #(.N_DIGITS(6), .SCAN_DIV(S), .BLANK_CYCLES(B)) dut6 (
    .clock(clk), .reset(rst), .wr_bus(if6),
    .abcdefgh(seg6), .digit(dig6), .frame_start(fs6));

  logic [7:0] hex_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                               8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  int checks = 0;
  int errors = 0;

  // stimulus per instance
  bit         v_valid [2];
  int         v_idx   [2];
  logic [3:0] v_val   [2];
  bit         v_dp    [2];
  bit         v_en    [2];
  bit         v_cmt   [2];

  // reference model per instance
  int         nd    [2];
  int         tt    [2];
  logic [5:0] sh    [2][8];
  logic [5:0] ac    [2][8];
  bit         pend  [2];
  bit         cd_e  [2];
  bit         fs_e  [2];
  bit         rdy_e [2];
  bit         armed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    if4.wr_valid  = v_valid[0];
    if4.wr_index  = v_idx[0][1:0];
    if4.wr_value  = v_val[0];
    if4.wr_dp     = v_dp[0];
    if4.wr_enable = v_en[0];
    if4.commit    = v_cmt[0];
    if6.wr_valid  = v_valid[1];
    if6.wr_index  = v_idx[1][2:0];
    if6.wr_value  = v_val[1];
    if6.wr_dp     = v_dp[1];
    if6.wr_enable = v_en[1];
    if6.commit    = v_cmt[1];
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      v_valid[k] = 0; v_idx[k] = 0; v_val[k] = 4'h0;
      v_dp[k] = 0; v_en[k] = 0; v_cmt[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int  f;
    bit  boundary;
    f = nd[k] * SLOT;
    if (rst) begin
      tt[k] = 0;
      for (int i = 0; i < 8; i++) begin
        sh[k][i] = '0;
        ac[k][i] = '0;
      end
      pend[k] = 0; cd_e[k] = 0; fs_e[k] = 0; rdy_e[k] = 0;
      armed = 1;
    end else begin
      boundary = ((tt[k] % f) == f - 1);
      if (v_valid[k] && rdy_e[k] && v_idx[k] < nd[k])
        sh[k][v_idx[k]] = {v_en[k], v_dp[k], v_val[k]};
      cd_e[k] = 0;
      if (boundary && pend[k]) begin
        for (int i = 0; i < 8; i++) ac[k][i] = sh[k][i];
        pend[k] = 0;
        cd_e[k] = 1;
      end else if (v_cmt[k] && !pend[k]) begin
        pend[k] = 1;
      end
      tt[k]++;
      fs_e[k]  = ((tt[k] % f) == 0);
      rdy_e[k] = !pend[k];
    end
  endtask

  task automatic exp_disp(input int k, output logic [7:0] dg, output logic [7:0] sg);
    int pos, slot, off;
    logic [5:0] e;
    logic [7:0] h;
    pos  = tt[k] % (nd[k] * SLOT);
    slot = pos / SLOT;
    off  = pos % SLOT;
    dg = 8'h00;
    sg = 8'h00;
    if (off >= B) begin
      e = ac[k][slot];
      if (e[5]) begin
        h  = hex_tab[e[3:0]];
        dg = 8'(1 << slot);
        sg = {h[7:1], e[4]};
      end
    end
  endtask

  // One clock: present inputs, advance model at the edge, compare 1 unit later.
  task automatic tick();
    logic [7:0] edg, esg;
    drive();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (armed) begin
      exp_disp(0, edg, esg);
      chk("digit4", 32'(dig4), 32'(edg));
      chk("seg4", 32'(seg4), 32'(esg));
      chk("ready4", 32'(if4.wr_ready), 32'(rdy_e[0]));
      chk("cdone4", 32'(if4.commit_done), 32'(cd_e[0]));
      chk("fstart4", 32'(fs4), 32'(fs_e[0]));
      exp_disp(1, edg, esg);
      chk("digit6", 32'(dig6), 32'(edg));
      chk("seg6", 32'(seg6), 32'(esg));
      chk("ready6", 32'(if6.wr_ready), 32'(rdy_e[1]));
      chk("cdone6", 32'(if6.commit_done), 32'(cd_e[1]));
      chk("fstart6", 32'(fs6), 32'(fs_e[1]));
    end
  endtask

  task automatic wait_cd(input int k, input int budget);
    int n;
    bit found;
    n = 0;
    found = 0;
    while (!found && n < budget) begin
      tick();
      n++;
      if ((k == 0) ? if4.commit_done : if6.commit_done) found = 1;
    end
    chk("commit_done_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_pos(input int k, input int pos);
    int n;
    n = 0;
    while ((tt[k] % (nd[k] * SLOT)) != pos && n < 100) begin
      tick();
      n++;
    end
  endtask

  int fcount, lit, cdcount, n;

  initial begin
    nd[0] = 4;
    nd[1] = 6;
    armed = 0;
    clear_inputs();
    rst = 1;

    // reset for 3 cycles, then idle
    repeat (3) tick();
    rst = 0;
    tick();
    chk("t1_ready_after_reset", 32'(if4.wr_ready), 32'd1);
    fcount = 0;
    lit = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (fs4) fcount++;
      if (dig4 != 0 || seg4 != 0) lit++;
    end
    chk("t1_frame_starts", 32'(fcount), 32'd2);
    chk("t1_dark_cycles", 32'(lit), 32'd0);

    // write digit 0 = 3, then commit
    v_valid[0] = 1; v_idx[0] = 0; v_val[0] = 4'h3; v_en[0] = 1; v_dp[0] = 0;
    tick();
    v_valid[0] = 0; v_cmt[0] = 1;
    tick();
    v_cmt[0] = 0;
    wait_cd(0, 60);
    wait_pos(0, 2);
    chk("t2_digit", 32'(dig4), 32'h1);
    chk("t2_seg", 32'(seg4), 32'hF2);

    // write and commit in the same cycle
    v_valid[0] = 1; v_idx[0] = 3; v_val[0] = 4'hF; v_en[0] = 1; v_dp[0] = 1; v_cmt[0] = 1;
    tick();
    clear_inputs();
    wait_cd(0, 60);
    wait_pos(0, 20);
    chk("t3_digit", 32'(dig4), 32'h8);
    chk("t3_seg", 32'(seg4), 32'h8F);

    // write held while pending
    v_cmt[0] = 1;
    tick();
    v_cmt[0] = 0;
    v_valid[0] = 1; v_idx[0] = 1; v_val[0] = 4'h5; v_en[0] = 1; v_dp[0] = 0;
    chk("t4_ready_low", 32'(if4.wr_ready), 32'd0);
    n = 0;
    while (!if4.wr_ready && n < 60) begin
      tick();
      n++;
    end
    chk("t4_ready_with_done", 32'(if4.commit_done), 32'd1);
    tick();
    v_valid[0] = 0;
    wait_pos(0, 8);
    chk("t4_not_yet_shown", 32'(dig4), 32'h0);
    v_cmt[0] = 1;
    tick();
    v_cmt[0] = 0;
    wait_cd(0, 60);
    wait_pos(0, 8);
    chk("t4_digit", 32'(dig4), 32'h2);
    chk("t4_seg", 32'(seg4), 32'hB6);

    // 6-digit build: index 5 lands, 6 and 7 are dropped
    v_valid[1] = 1; v_idx[1] = 5; v_val[1] = 4'h7; v_en[1] = 1; v_dp[1] = 0;
    tick();
    v_idx[1] = 6; v_val[1] = 4'h8;
    tick();
    v_idx[1] = 7;
    tick();
    v_valid[1] = 0; v_cmt[1] = 1;
    tick();
    v_cmt[1] = 0;
    wait_cd(1, 80);
    lit = 0;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (tt[1] % 36 == 32) begin
        chk("t5_digit", 32'(dig6), 32'h20);
        chk("t5_seg", 32'(seg6), 32'hE0);
      end
      if (dig6 != 0 && dig6 != 6'h20) lit++;
    end
    chk("t5_no_other_digits", 32'(lit), 32'd0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 2; k++) begin
        v_valid[k] = 1'($urandom_range(0, 1));
        v_idx[k]   = int'($urandom_range(0, (k == 0) ? 3 : 7));
        v_val[k]   = 4'($urandom_range(0, 15));
        v_dp[k]    = 1'($urandom_range(0, 1));
        v_en[k]    = 1'($urandom_range(0, 1));
        v_cmt[k]   = ($urandom_range(0, 19) == 0);
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();

    // reset mid-SHOW with a commit pending
    v_valid[0] = 1; v_idx[0] = 2; v_val[0] = 4'hA; v_en[0] = 1; v_dp[0] = 0;
    tick();
    v_valid[0] = 0; v_cmt[0] = 1;
    tick();
    v_cmt[0] = 0;
    wait_cd(0, 60);
    v_cmt[0] = 1;
    tick();
    v_cmt[0] = 0;
    wait_pos(0, 9);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_digit", 32'(dig4), 32'h0);
    chk("t6_seg", 32'(seg4), 32'h0);
    chk("t6_ready", 32'(if4.wr_ready), 32'h0);
    lit = 0;
    cdcount = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (dig4 != 0) lit++;
      if (if4.commit_done) cdcount++;
    end
    chk("t6_all_dark", 32'(lit), 32'd0);
    chk("t6_pending_dropped", 32'(cdcount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
